// File: rtl/pi1_arbiter_pkg.sv
// pi1_arbiter_pkg
//   Definitions shared by every pi1 block: the two-bit pi1 operation codes
//   and a constant-foldable ceiling-log2 used to size address and index
//   fields from parameters.
package pi1_arbiter_pkg;

  localparam logic [1:0] PINOOP = 2'd0;  // idle, no request
  localparam logic [1:0] PIWROP = 2'd1;  // write
  localparam logic [1:0] PIRDOP = 2'd2;  // read
  localparam logic [1:0] PIRWOP = 2'd3;  // read-then-write (swap)

  // Smallest r with 2**r >= value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pi1_arbiter_rrpick.sv
// pi1_arbiter_rrpick
//   Purely combinational round-robin picker. Scans the request vector
//   starting at ptr_i and wrapping modulo N, and returns the first
//   requesting index. With no request, idx_o echoes ptr_i so the slave
//   side muxes stay parked on a well-defined master.
//
//   req_i  in   N  one bit per master, 1 = requesting
//   ptr_i  in   W  highest-priority index (must be < N)
//   idx_o  out  W  selected index
//   vld_o  out  1  at least one request present
module pi1_arbiter_rrpick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         vld_o
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  localparam logic [W:0] NV = (W+1)'(N);

  logic [W:0] cand;

  // Scanning from the farthest offset down to offset 0 lets the nearest
  // requester (lowest offset from ptr_i) overwrite earlier hits. The wrap is
  // a single conditional subtract, so non-power-of-2 counts need no divider.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a
    // path that leaves one unassigned would infer a latch.
    idx_o = ptr_i;
    vld_o = 1'b0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_i} + (W+1)'(k);
      if (cand >= NV) cand = cand - NV;
      if (req_i[cand[W-1:0]]) begin
        idx_o = cand[W-1:0];
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pi1_arbiter.sv
// pi1_arbiter
//   Round-robin arbiter sharing one pi1 slave port between MASTERCOUNT pi1
//   masters. The request path is combinational; the grant is frozen while
//   the slave stalls a started request, and priority rotates to the master
//   after the granted one on every accepted request.
//
//   clk_i           in   1                clock, all state on rising edge
//   rst_ni          in   1                asynchronous active-low reset
//   m_pi1_op_i      in   2*MC             per-master op, master i at [2*i+:2]
//   m_pi1_addr_i    in   ADDRBITSZ*MC     per-master word address
//   m_pi1_data_i    in   ARCHBITSZ*MC     per-master write data
//   m_pi1_data_o    out  ARCHBITSZ*MC     read data, every slice = s_pi1_data_i
//   m_pi1_sel_i     in   SELBITSZ*MC      per-master byte selects
//   m_pi1_rdy_o     out  MC               per-master ready
//   m_pi1_mapsz_o   out  ADDRBITSZ*MC     every slice = s_pi1_mapsz_i
//   s_pi1_op_o      out  2                op to slave
//   s_pi1_addr_o    out  ADDRBITSZ        granted master's address
//   s_pi1_data_o    out  ARCHBITSZ        granted master's write data
//   s_pi1_data_i    in   ARCHBITSZ        slave read data
//   s_pi1_sel_o     out  SELBITSZ         granted master's byte selects
//   s_pi1_rdy_i     in   1                slave ready
//   s_pi1_mapsz_i   in   ADDRBITSZ        slave map size
module pi1_arbiter
  import pi1_arbiter_pkg::*;
#(
  parameter  int MASTERCOUNT = 2,
  parameter  int ARCHBITSZ   = 32,
  localparam int ADDRBITSZ   = ARCHBITSZ - clog2(ARCHBITSZ / 8),
  localparam int SELBITSZ    = ARCHBITSZ / 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [2*MASTERCOUNT-1:0]         m_pi1_op_i,
  input  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_pi1_addr_i,
  input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_pi1_data_i,
  output logic [ARCHBITSZ*MASTERCOUNT-1:0] m_pi1_data_o,
  input  logic [SELBITSZ*MASTERCOUNT-1:0]  m_pi1_sel_i,
  output logic [MASTERCOUNT-1:0]           m_pi1_rdy_o,
  output logic [ADDRBITSZ*MASTERCOUNT-1:0] m_pi1_mapsz_o,
  output logic [1:0]                       s_pi1_op_o,
  output logic [ADDRBITSZ-1:0]             s_pi1_addr_o,
  output logic [ARCHBITSZ-1:0]             s_pi1_data_o,
  input  logic [ARCHBITSZ-1:0]             s_pi1_data_i,
  output logic [SELBITSZ-1:0]              s_pi1_sel_o,
  input  logic                             s_pi1_rdy_i,
  input  logic [ADDRBITSZ-1:0]             s_pi1_mapsz_i
);

  // A single master still gets a one-bit index that simply stays 0.
  localparam int              PTRW    = (MASTERCOUNT > 1) ? clog2(MASTERCOUNT) : 1;
  localparam logic [PTRW-1:0] LASTIDX = PTRW'(MASTERCOUNT - 1);

  logic [1:0]           op_m   [MASTERCOUNT];
  logic [ADDRBITSZ-1:0] addr_m [MASTERCOUNT];
  logic [ARCHBITSZ-1:0] data_m [MASTERCOUNT];
  logic [SELBITSZ-1:0]  sel_m  [MASTERCOUNT];
  logic [MASTERCOUNT-1:0] req;

  logic [PTRW-1:0] ptr_q, ptr_d;
  logic            lock_q, lock_d;
  logic [PTRW-1:0] lockidx_q, lockidx_d;

  logic [PTRW-1:0] pick_idx;
  logic            pick_vld;
  logic [PTRW-1:0] gnt;
  logic            gntvld;
  logic            s_active;

  for (genvar i = 0; i < MASTERCOUNT; i++) begin : g_slice
    assign op_m[i]   = m_pi1_op_i[2*i +: 2];
    assign addr_m[i] = m_pi1_addr_i[ADDRBITSZ*i +: ADDRBITSZ];
    assign data_m[i] = m_pi1_data_i[ARCHBITSZ*i +: ARCHBITSZ];
    assign sel_m[i]  = m_pi1_sel_i[SELBITSZ*i +: SELBITSZ];
    assign req[i]    = (op_m[i] != PINOOP);
    // Idle masters see slave ready so they can qualify returned read data;
    // a waiting requester sees 0 and must hold its request.
    assign m_pi1_rdy_o[i] = s_pi1_rdy_i &
                            ((gntvld & (gnt == PTRW'(i))) | (op_m[i] == PINOOP));
  end

  pi1_arbiter_rrpick #(
    .N (MASTERCOUNT),
    .W (PTRW)
  ) u_rrpick (
    .req_i (req),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  // A stalled request keeps its master; new requests cannot steal the bus.
  assign gnt    = lock_q ? lockidx_q : pick_idx;
  assign gntvld = lock_q | pick_vld;

  // If the locked master drops its op, this naturally shows NOOP.
  assign s_pi1_op_o   = gntvld ? op_m[gnt] : PINOOP;
  assign s_pi1_addr_o = addr_m[gnt];
  assign s_pi1_data_o = data_m[gnt];
  assign s_pi1_sel_o  = sel_m[gnt];
  assign s_active     = (s_pi1_op_o != PINOOP);

  assign m_pi1_data_o  = {MASTERCOUNT{s_pi1_data_i}};
  assign m_pi1_mapsz_o = {MASTERCOUNT{s_pi1_mapsz_i}};

  always_comb begin
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    lockidx_d = lockidx_q;
    if (s_active && s_pi1_rdy_i) begin
      // Accept: the master after the granted one gets top priority.
      ptr_d  = (gnt == LASTIDX) ? '0 : gnt + PTRW'(1);
      lock_d = 1'b0;
    end else if (s_active && !lock_q) begin
      // First stalled cycle: freeze the grant.
      lock_d    = 1'b1;
      lockidx_d = gnt;
    end else if (!s_active) begin
      // Locked master withdrew its request; release without rotating.
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_ni) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lockidx_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lockidx_q <= lockidx_d;
    end
  end

endmodule

// File: tb/tb_pi1_arbiter.sv
module tb_pi1_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = 4;

  int checks   = 0;
  int failures = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] sdata;
  logic [AW-1:0] mapsz;

  // Four-master instance
  logic [7:0]      op4;
  logic [4*AW-1:0] addr4, mapsz4;
  logic [4*DW-1:0] wd4, rd4;
  logic [4*SW-1:0] sel4;
  logic [3:0]      mrdy4;
  logic [1:0]      sop4;
  logic [AW-1:0]   saddr4;
  logic [DW-1:0]   swd4;
  logic [SW-1:0]   ssel4;
  logic            rdy4;

  // Three-master instance
  logic [5:0]      op3;
  logic [3*AW-1:0] addr3, mapsz3;
  logic [3*DW-1:0] wd3, rd3;
  logic [3*SW-1:0] sel3;
  logic [2:0]      mrdy3;
  logic [1:0]      sop3;
  logic [AW-1:0]   saddr3;
  logic [DW-1:0]   swd3;
  logic [SW-1:0]   ssel3;
  logic            rdy3;

  pi1_arbiter #(.MASTERCOUNT(4), .ARCHBITSZ(DW)) dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .m_pi1_op_i(op4), .m_pi1_addr_i(addr4), .m_pi1_data_i(wd4),
    .m_pi1_data_o(rd4), .m_pi1_sel_i(sel4), .m_pi1_rdy_o(mrdy4),
    .m_pi1_mapsz_o(mapsz4),
    .s_pi1_op_o(sop4), .s_pi1_addr_o(saddr4), .s_pi1_data_o(swd4),
    .s_pi1_data_i(sdata), .s_pi1_sel_o(ssel4), .s_pi1_rdy_i(rdy4),
    .s_pi1_mapsz_i(mapsz)
  );

  pi1_arbiter #(.MASTERCOUNT(3), .ARCHBITSZ(DW)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .m_pi1_op_i(op3), .m_pi1_addr_i(addr3), .m_pi1_data_i(wd3),
    .m_pi1_data_o(rd3), .m_pi1_sel_i(sel3), .m_pi1_rdy_o(mrdy3),
    .m_pi1_mapsz_o(mapsz3),
    .s_pi1_op_o(sop3), .s_pi1_addr_o(saddr3), .s_pi1_data_o(swd3),
    .s_pi1_data_i(sdata), .s_pi1_sel_o(ssel3), .s_pi1_rdy_i(rdy3),
    .s_pi1_mapsz_i(mapsz)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < 4; i++) begin
      addr4[AW*i +: AW] = AW'($urandom);
      wd4[DW*i +: DW]   = $urandom;
      sel4[SW*i +: SW]  = SW'($urandom);
    end
    for (int i = 0; i < 3; i++) begin
      addr3[AW*i +: AW] = AW'($urandom);
      wd3[DW*i +: DW]   = $urandom;
      sel3[SW*i +: SW]  = SW'($urandom);
    end
    sdata = $urandom;
    mapsz = AW'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    op4 = '0; op3 = '0; rdy4 = 1'b1; rdy3 = 1'b1;
    rand_payload();
    #1;
    checks++; if (sop4 !== 2'd0) begin failures++; $display("FAIL reset_sop4: got %0d expected 0", sop4); end
    checks++; if (mrdy4 !== 4'hf) begin failures++; $display("FAIL reset_mrdy4: got %b expected 1111", mrdy4); end
    checks++; if (mrdy3 !== 3'h7) begin failures++; $display("FAIL reset_mrdy3: got %b expected 111", mrdy3); end
    checks++; if (saddr4 !== addr4[AW-1:0]) begin failures++; $display("FAIL reset_saddr4: got %h expected %h", saddr4, addr4[AW-1:0]); end
    checks++; if (swd4 !== wd4[DW-1:0]) begin failures++; $display("FAIL reset_swd4: got %h expected %h", swd4, wd4[DW-1:0]); end
    checks++; if (ssel4 !== sel4[SW-1:0]) begin failures++; $display("FAIL reset_ssel4: got %h expected %h", ssel4, sel4[SW-1:0]); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (sop3 !== 2'd0) begin failures++; $display("FAIL post_reset_sop3: got %0d expected 0", sop3); end
    checks++; if (saddr3 !== addr3[AW-1:0]) begin failures++; $display("FAIL post_reset_saddr3: got %h expected %h", saddr3, addr3[AW-1:0]); end
    tick();
  endtask

  // Masters 1 and 3 read continuously; accepts must alternate 1,3,1,3.
  task automatic test_alternate();
    int eg;
    op4 = 8'b10_00_10_00; rdy4 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      eg = (k % 2 == 0) ? 1 : 3;
      #1;
      checks++; if (sop4 !== 2'd2) begin failures++; $display("FAIL alt_sop[%0d]: got %0d expected 2", k, sop4); end
      checks++; if (saddr4 !== addr4[AW*eg +: AW]) begin failures++; $display("FAIL alt_saddr[%0d]: got %h expected %h", k, saddr4, addr4[AW*eg +: AW]); end
      checks++; if (mrdy4 !== ((eg == 1) ? 4'b0111 : 4'b1101)) begin failures++; $display("FAIL alt_mrdy[%0d]: got %b expected gnt %0d", k, mrdy4, eg); end
      tick();
    end
    op4 = '0;
  endtask

  // Master 2 stalls three cycles while master 0 waits; then 2 then 0.
  task automatic test_stall();
    addr4[AW*2 +: AW] = AW'(30'h10);
    op4 = 8'b00_01_00_00; rdy4 = 1'b0;
    #1;
    checks++; if (sop4 !== 2'd1 || saddr4 !== AW'(30'h10)) begin failures++; $display("FAIL stall_first: got op %0d addr %h expected op 1 addr 10", sop4, saddr4); end
    checks++; if (mrdy4 !== 4'b0000) begin failures++; $display("FAIL stall_mrdy: got %b expected 0000", mrdy4); end
    tick();
    op4 = 8'b00_01_00_10;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (sop4 !== 2'd1 || saddr4 !== AW'(30'h10)) begin failures++; $display("FAIL stall_hold[%0d]: got op %0d addr %h expected op 1 addr 10", k, sop4, saddr4); end
      tick();
    end
    rdy4 = 1'b1;
    #1;
    checks++; if (sop4 !== 2'd1 || saddr4 !== AW'(30'h10)) begin failures++; $display("FAIL stall_accept: got op %0d addr %h expected op 1 addr 10", sop4, saddr4); end
    checks++; if (mrdy4 !== 4'b1110) begin failures++; $display("FAIL stall_accept_mrdy: got %b expected 1110", mrdy4); end
    tick();
    #1;
    checks++; if (sop4 !== 2'd2 || saddr4 !== addr4[AW-1:0]) begin failures++; $display("FAIL stall_next: got op %0d addr %h expected op 2 addr %h", sop4, saddr4, addr4[AW-1:0]); end
    checks++; if (mrdy4 !== 4'b1011) begin failures++; $display("FAIL stall_next_mrdy: got %b expected 1011", mrdy4); end
    tick();
    op4 = '0;
  endtask

  task automatic test_read_data();
    op4 = 8'b00_00_00_10; rdy4 = 1'b1;
    #1;
    checks++; if (mrdy4[0] !== 1'b1 || sop4 !== 2'd2) begin failures++; $display("FAIL rd_req: got rdy %b op %0d expected rdy 1 op 2", mrdy4[0], sop4); end
    tick();
    op4 = '0; sdata = 32'hCAFEF00D;
    #1;
    checks++; if (mrdy4 !== 4'hf) begin failures++; $display("FAIL rd_mrdy: got %b expected 1111", mrdy4); end
    checks++; if (rd4[DW-1:0] !== 32'hCAFEF00D) begin failures++; $display("FAIL rd_data: got %h expected cafef00d", rd4[DW-1:0]); end
    checks++; if (mapsz4[AW*3 +: AW] !== mapsz) begin failures++; $display("FAIL rd_mapsz: got %h expected %h", mapsz4[AW*3 +: AW], mapsz); end
    tick();
  endtask

  // Locked master withdraws; bus shows NOOP, lock releases, priority kept.
  task automatic test_drop();
    op4 = 8'b00_00_10_00; rdy4 = 1'b0;
    #1;
    checks++; if (saddr4 !== addr4[AW*1 +: AW]) begin failures++; $display("FAIL drop_lock_addr: got %h expected %h", saddr4, addr4[AW*1 +: AW]); end
    tick();
    op4 = 8'b10_00_00_00; rdy4 = 1'b1;
    #1;
    checks++; if (sop4 !== 2'd0) begin failures++; $display("FAIL drop_sop: got %0d expected 0", sop4); end
    checks++; if (mrdy4 !== 4'b0111) begin failures++; $display("FAIL drop_mrdy: got %b expected 0111", mrdy4); end
    tick();
    op4 = 8'b00_10_00_10;
    #1;
    checks++; if (sop4 !== 2'd2 || saddr4 !== addr4[AW*2 +: AW]) begin failures++; $display("FAIL drop_after: got op %0d addr %h expected op 2 addr %h", sop4, saddr4, addr4[AW*2 +: AW]); end
    tick();
    op4 = '0;
  endtask

  // Three masters all requesting: grant order 0,1,2,0,1,2.
  task automatic test_mc3();
    op3 = 6'b10_10_10; rdy3 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (saddr3 !== addr3[AW*(k%3) +: AW]) begin failures++; $display("FAIL mc3_saddr[%0d]: got %h expected %h", k, saddr3, addr3[AW*(k%3) +: AW]); end
      checks++; if (mrdy3 !== (3'b001 << (k % 3))) begin failures++; $display("FAIL mc3_mrdy[%0d]: got %b expected gnt %0d", k, mrdy3, k % 3); end
      tick();
    end
    op3 = '0;
  endtask

  task automatic test_reset_locked();
    op4 = 8'b00_00_10_00; rdy4 = 1'b0;
    #1;
    tick();
    op4 = 8'b00_00_10_10;
    #1;
    checks++; if (saddr4 !== addr4[AW*1 +: AW]) begin failures++; $display("FAIL rstlock_hold: got %h expected %h", saddr4, addr4[AW*1 +: AW]); end
    rst_n = 1'b0;
    #1;
    checks++; if (sop4 !== 2'd2 || saddr4 !== addr4[AW-1:0]) begin failures++; $display("FAIL rstlock_cleared: got op %0d addr %h expected op 2 addr %h", sop4, saddr4, addr4[AW-1:0]); end
    tick();
    rst_n = 1'b1; rdy4 = 1'b1;
    #1;
    checks++; if (saddr4 !== addr4[AW-1:0]) begin failures++; $display("FAIL rstlock_tie: got %h expected %h", saddr4, addr4[AW-1:0]); end
    checks++; if (mrdy4 !== 4'b1101) begin failures++; $display("FAIL rstlock_mrdy: got %b expected 1101", mrdy4); end
    tick();
    op4 = '0;
  endtask

  // Random traffic on both instances against a priority/owner model:
  // the owner is the master whose request is stuck at the slave; otherwise
  // the winner is the first requester in circular order starting just
  // after the last accepted master.
  task automatic test_random();
    int prio [2];
    int owner [2];
    int sg [2];
    int sop [2];
    logic srdy [2];
    int n, g;
    bit vld;
    logic [7:0]      ops;
    logic [4*AW-1:0] addrs, o_map, e_map;
    logic [4*DW-1:0] wds, o_rd, e_rd;
    logic [4*SW-1:0] sels;
    logic [1:0]      o_op, e_op;
    logic [AW-1:0]   o_addr;
    logic [DW-1:0]   o_wd;
    logic [SW-1:0]   o_sel;
    logic [3:0]      o_rdy, e_rdy;

    rst_n = 1'b0; op4 = '0; op3 = '0;
    #1;
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin prio[d] = 0; owner[d] = -1; end
    tick();

    for (int cyc = 0; cyc < 400; cyc++) begin
      rand_payload();
      op4  = 8'($urandom);
      op3  = 6'($urandom);
      rdy4 = ($urandom_range(0, 9) < 7);
      rdy3 = ($urandom_range(0, 9) < 7);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (d == 0) begin
          n = 4; ops = op4; addrs = addr4; wds = wd4; sels = sel4; srdy[d] = rdy4;
          o_op = sop4; o_addr = saddr4; o_wd = swd4; o_sel = ssel4;
          o_rdy = mrdy4; o_rd = rd4; o_map = mapsz4;
        end else begin
          n = 3; ops = 8'(op3); addrs = (4*AW)'(addr3); wds = (4*DW)'(wd3);
          sels = (4*SW)'(sel3); srdy[d] = rdy3;
          o_op = sop3; o_addr = saddr3; o_wd = swd3; o_sel = ssel3;
          o_rdy = 4'(mrdy3); o_rd = (4*DW)'(rd3); o_map = (4*AW)'(mapsz3);
        end
        if (owner[d] >= 0) begin
          g = owner[d]; vld = 1'b1;
        end else begin
          g = prio[d]; vld = 1'b0;
          for (int k = 0; k < n; k++) begin
            int c;
            c = (prio[d] + k) % n;
            if (!vld && ops[2*c +: 2] != 2'd0) begin g = c; vld = 1'b1; end
          end
        end
        e_op = vld ? ops[2*g +: 2] : 2'd0;
        e_rdy = '0; e_rd = '0; e_map = '0;
        for (int i = 0; i < n; i++) begin
          e_rdy[i] = srdy[d] & ((vld && g == i) || ops[2*i +: 2] == 2'd0);
          e_rd[DW*i +: DW] = sdata;
          e_map[AW*i +: AW] = mapsz;
        end
        checks++; if (o_op !== e_op) begin failures++; $display("FAIL rnd%0d_sop[%0d]: got %0d expected %0d", n, cyc, o_op, e_op); end
        checks++; if (o_addr !== addrs[AW*g +: AW]) begin failures++; $display("FAIL rnd%0d_saddr[%0d]: got %h expected %h", n, cyc, o_addr, addrs[AW*g +: AW]); end
        checks++; if (o_wd !== wds[DW*g +: DW]) begin failures++; $display("FAIL rnd%0d_swd[%0d]: got %h expected %h", n, cyc, o_wd, wds[DW*g +: DW]); end
        checks++; if (o_sel !== sels[SW*g +: SW]) begin failures++; $display("FAIL rnd%0d_ssel[%0d]: got %h expected %h", n, cyc, o_sel, sels[SW*g +: SW]); end
        checks++; if (o_rdy !== e_rdy) begin failures++; $display("FAIL rnd%0d_mrdy[%0d]: got %b expected %b", n, cyc, o_rdy, e_rdy); end
        checks++; if (o_rd !== e_rd) begin failures++; $display("FAIL rnd%0d_mdata[%0d]: got %h expected %h", n, cyc, o_rd, e_rd); end
        checks++; if (o_map !== e_map) begin failures++; $display("FAIL rnd%0d_mapsz[%0d]: got %h expected %h", n, cyc, o_map, e_map); end
        sg[d] = g; sop[d] = int'(e_op);
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        n = (d == 0) ? 4 : 3;
        if (sop[d] != 0 && srdy[d]) begin
          prio[d] = (sg[d] + 1) % n; owner[d] = -1;
        end else if (sop[d] != 0) begin
          owner[d] = sg[d];
        end else begin
          owner[d] = -1;
        end
      end
    end
    op4 = '0; op3 = '0;
  endtask

  initial begin
    op4 = '0; op3 = '0; rdy4 = 1'b0; rdy3 = 1'b0;
    addr4 = '0; wd4 = '0; sel4 = '0; addr3 = '0; wd3 = '0; sel3 = '0;
    sdata = '0; mapsz = '0;
    test_reset();
    test_alternate();
    test_stall();
    test_read_data();
    test_drop();
    test_mc3();
    test_reset_locked();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
